// File: rtl/pattern_scan_ctrl_if.sv
// Handshake/config/status bundle for pattern_scan_ctrl.
// master drives configuration and the bitstream; slave is the controller.
interface pattern_scan_ctrl_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic [CNT_W-1:0]   cfg_max_hits;
   logic               start;
   logic               stop;
   logic               bit_valid;
   logic               bit_in;
   logic               match;
   logic [CNT_W-1:0]   match_count;
   logic               busy;
   logic               done;
   logic               cfg_err;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_max_hits,
      output start, stop, bit_valid, bit_in,
      input  match, match_count, busy, done, cfg_err
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_max_hits,
      input  start, stop, bit_valid, bit_in,
      output match, match_count, busy, done, cfg_err
   );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Run-time configurable serial pattern detector with overlap control and
// a hit limit that parks the controller in DONE.
module pattern_scan_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input logic               clk,
   input logic               rst,
   pattern_scan_ctrl_if.slave bus
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0]   FILL_MAX = LEN_W'(MAX_LEN);
   localparam logic [MAX_LEN-1:0] PAT_RST  = MAX_LEN'(4'b1011);
   localparam logic [LEN_W-1:0]   LEN_RST  = LEN_W'(4);

   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [CNT_W-1:0]   maxh_q, maxh_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               match_q, match_d;
   logic               err_q, err_d;

   logic [MAX_LEN-1:0] mask;
   logic [MAX_LEN-1:0] hist_sh;
   logic [LEN_W-1:0]   fill_inc;
   logic [CNT_W-1:0]   cnt_inc;
   logic               len_ok;
   logic               hit;

   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LEN_W'(i) < len_q);
      end
   end

   // Hit is judged on the post-shift history and post-increment fill count.
   always_comb begin
      hist_sh  = MAX_LEN'({hist_q, bus.bit_in});
      fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
      cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      len_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= FILL_MAX);
      hit      = (fill_inc >= len_q) && (((hist_sh ^ pat_q) & mask) == '0);
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      maxh_d  = maxh_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      match_d = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cfg_we) begin
               if (len_ok) begin
                  pat_d  = bus.cfg_pattern;
                  len_d  = bus.cfg_len;
                  ovl_d  = bus.cfg_overlap;
                  maxh_d = bus.cfg_max_hits;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (bus.start) begin
               state_d = ARMED;
               cnt_d   = '0;
               hist_d  = '0;
               fill_d  = '0;
            end
         end
         ARMED: begin
            if (bus.bit_valid) begin
               hist_d = hist_sh;
               fill_d = fill_inc;
               if (hit) begin
                  match_d = 1'b1;
                  cnt_d   = cnt_inc;
                  if (!ovl_q) fill_d = '0;
                  if ((maxh_q != '0) && (cnt_inc == maxh_q)) state_d = DONE;
               end
            end
            // A hit on the stop cycle is still counted; stop overrides DONE.
            if (bus.stop) state_d = IDLE;
         end
         DONE: begin
            if (bus.start) begin
               state_d = ARMED;
               cnt_d   = '0;
               hist_d  = '0;
               fill_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pat_q   <= PAT_RST;
         len_q   <= LEN_RST;
         ovl_q   <= 1'b1;
         maxh_q  <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         match_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         maxh_q  <= maxh_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
         err_q   <= err_d;
      end
   end

   assign bus.match       = match_q;
   assign bus.match_count = cnt_q;
   assign bus.busy        = (state_q == ARMED);
   assign bus.done        = (state_q == DONE);
   assign bus.cfg_err     = err_q;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed vector bench for pattern_scan_ctrl: one table of per-cycle
// stimulus/expectation records plus hand-written gapped and reset sequences.
module tb_pattern_scan_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   pattern_scan_ctrl_if #(.MAX_LEN(8), .CNT_W(8)) bus ();

   pattern_scan_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       we;
      logic [7:0] pat;
      logic [3:0] len;
      logic       ovl;
      logic [7:0] mh;
      logic       st;
      logic       sp;
      logic       bv;
      logic       bi;
      logic       em;
      logic [7:0] ec;
      logic       eb;
      logic       ed;
      logic       ee;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int we, input int pat, input int len, input int ovl,
                               input int mh, input int st, input int sp, input int bv,
                               input int bi, input int em, input int ec, input int eb,
                               input int ed, input int ee);
      vec_t r;
      r.we = we[0];  r.pat = pat[7:0]; r.len = len[3:0]; r.ovl = ovl[0];
      r.mh = mh[7:0]; r.st = st[0];    r.sp = sp[0];     r.bv = bv[0];
      r.bi = bi[0];  r.em = em[0];     r.ec = ec[7:0];   r.eb = eb[0];
      r.ed = ed[0];  r.ee = ee[0];
      return r;
   endfunction

   // One valid data bit, no control activity.
   function automatic vec_t bt(input int b, input int em, input int ec, input int eb, input int ed);
      return mk(0, 0, 0, 0, 0, 0, 0, 1, b, em, ec, eb, ed, 0);
   endfunction

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t r, input int idx);
      bus.cfg_we       = r.we;
      bus.cfg_pattern  = r.pat;
      bus.cfg_len      = r.len;
      bus.cfg_overlap  = r.ovl;
      bus.cfg_max_hits = r.mh;
      bus.start        = r.st;
      bus.stop         = r.sp;
      bus.bit_valid    = r.bv;
      bus.bit_in       = r.bi;
      @(posedge clk);
      #1;
      chk("match",   idx, int'(bus.match),       int'(r.em));
      chk("count",   idx, int'(bus.match_count), int'(r.ec));
      chk("busy",    idx, int'(bus.busy),        int'(r.eb));
      chk("done",    idx, int'(bus.done),        int'(r.ed));
      chk("cfg_err", idx, int'(bus.cfg_err),     int'(r.ee));
   endtask

   task automatic check_zero(input int idx);
      chk("rst_match", idx, int'(bus.match),       0);
      chk("rst_count", idx, int'(bus.match_count), 0);
      chk("rst_busy",  idx, int'(bus.busy),        0);
      chk("rst_done",  idx, int'(bus.done),        0);
      chk("rst_err",   idx, int'(bus.cfg_err),     0);
   endtask

   initial begin
      bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
      bus.cfg_max_hits = '0; bus.start = 1'b0; bus.stop = 1'b0;
      bus.bit_valid = 1'b0; bus.bit_in = 1'b0;

      // Default 1011, overlap: hits after bits 4 and 7
      vecs.push_back(mk(0,0,0,0,0, 1,0,0,0, 0,0,1,0,0));
      vecs.push_back(bt(1,0,0,1,0)); vecs.push_back(bt(0,0,0,1,0));
      vecs.push_back(bt(1,0,0,1,0)); vecs.push_back(bt(1,1,1,1,0));
      vecs.push_back(bt(0,0,1,1,0)); vecs.push_back(bt(1,0,1,1,0));
      vecs.push_back(bt(1,1,2,1,0));
      vecs.push_back(mk(0,0,0,0,0, 0,1,0,0, 0,2,0,0,0));
      // Non-overlap: hits after bits 4 and 11 only
      vecs.push_back(mk(1,'hB,4,0,0, 0,0,0,0, 0,2,0,0,0));
      vecs.push_back(mk(0,0,0,0,0, 1,0,0,0, 0,0,1,0,0));
      vecs.push_back(bt(1,0,0,1,0)); vecs.push_back(bt(0,0,0,1,0));
      vecs.push_back(bt(1,0,0,1,0)); vecs.push_back(bt(1,1,1,1,0));
      vecs.push_back(bt(0,0,1,1,0)); vecs.push_back(bt(1,0,1,1,0));
      vecs.push_back(bt(1,0,1,1,0)); vecs.push_back(bt(1,0,1,1,0));
      vecs.push_back(bt(0,0,1,1,0)); vecs.push_back(bt(1,0,1,1,0));
      vecs.push_back(bt(1,1,2,1,0));
      vecs.push_back(mk(0,0,0,0,0, 0,1,0,0, 0,2,0,0,0));
      // len = 1, overlap: back-to-back pulses
      vecs.push_back(mk(1,1,1,1,0, 0,0,0,0, 0,2,0,0,0));
      vecs.push_back(mk(0,0,0,0,0, 1,0,0,0, 0,0,1,0,0));
      vecs.push_back(bt(1,1,1,1,0)); vecs.push_back(bt(1,1,2,1,0));
      vecs.push_back(bt(0,0,2,1,0)); vecs.push_back(bt(1,1,3,1,0));
      vecs.push_back(mk(0,0,0,0,0, 0,1,0,0, 0,3,0,0,0));
      // Hit limit 2: stream 1011011011, DONE from the second pulse
      vecs.push_back(mk(1,'hB,4,1,2, 0,0,0,0, 0,3,0,0,0));
      vecs.push_back(mk(0,0,0,0,0, 1,0,0,0, 0,0,1,0,0));
      vecs.push_back(bt(1,0,0,1,0)); vecs.push_back(bt(0,0,0,1,0));
      vecs.push_back(bt(1,0,0,1,0)); vecs.push_back(bt(1,1,1,1,0));
      vecs.push_back(bt(0,0,1,1,0)); vecs.push_back(bt(1,0,1,1,0));
      vecs.push_back(bt(1,1,2,0,1));
      vecs.push_back(bt(0,0,2,0,1)); vecs.push_back(bt(1,0,2,0,1));
      vecs.push_back(bt(1,0,2,0,1));
      vecs.push_back(mk(0,0,0,0,0, 1,0,0,0, 0,0,1,0,0));
      vecs.push_back(mk(0,0,0,0,0, 0,1,0,0, 0,0,0,0,0));
      // Config guards: len 0 and len > MAX_LEN rejected, config kept
      vecs.push_back(mk(1,7,0,1,0, 0,0,0,0, 0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0));
      vecs.push_back(mk(1,7,9,1,0, 0,0,0,0, 0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0, 1,0,0,0, 0,0,1,0,0));
      vecs.push_back(bt(1,0,0,1,0)); vecs.push_back(bt(0,0,0,1,0));
      vecs.push_back(bt(1,0,0,1,0)); vecs.push_back(bt(1,1,1,1,0));
      // Write while ARMED ignored silently; 111 must not match
      vecs.push_back(mk(1,7,3,1,0, 0,0,0,0, 0,1,1,0,0));
      vecs.push_back(bt(1,0,1,1,0)); vecs.push_back(bt(1,0,1,1,0));
      vecs.push_back(bt(1,0,1,1,0));
      // Start while ARMED ignored; start+stop: stop wins, count kept
      vecs.push_back(mk(0,0,0,0,0, 1,0,1,0, 0,1,1,0,0));
      vecs.push_back(mk(0,0,0,0,0, 1,1,0,0, 0,1,0,0,0));
      // Hit on the stop cycle is still counted and pulsed
      vecs.push_back(mk(0,0,0,0,0, 1,0,0,0, 0,0,1,0,0));
      vecs.push_back(bt(1,0,0,1,0)); vecs.push_back(bt(0,0,0,1,0));
      vecs.push_back(bt(1,0,0,1,0));
      vecs.push_back(mk(0,0,0,0,0, 0,1,1,1, 1,1,0,0,0));

      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_zero(0);
      rst = 1'b0;

      foreach (vecs[i]) apply(vecs[i], i);

      // Gapped valid: pattern 0110, 3 idle cycles (bit_in junk) between bits
      apply(mk(1,'h6,4,1,0, 0,0,0,0, 0,1,0,0,0), 1000);
      apply(mk(0,0,0,0,0, 1,0,0,0, 0,0,1,0,0), 1001);
      begin
         logic [3:0] seq;
         seq = 4'b0110;
         for (int b = 3; b >= 0; b--) begin
            apply(bt(int'(seq[b]), (b == 0) ? 1 : 0, (b == 0) ? 1 : 0, 1, 0), 1010 + b);
            for (int g = 0; g < 3; g++)
               apply(mk(0,0,0,0,0, 0,0,0,1, 0, (b == 0) ? 1 : 0, 1, 0, 0), 1020 + b * 3 + g);
         end
      end

      // Reset mid-scan: outputs clear and config reverts to 1011/overlap
      apply(mk(0,0,0,0,0, 0,1,0,0, 0,1,0,0,0), 1100);
      apply(mk(0,0,0,0,0, 1,0,0,0, 0,0,1,0,0), 1101);
      apply(bt(1,0,0,1,0), 1102);
      apply(bt(0,0,0,1,0), 1103);
      apply(bt(1,0,0,1,0), 1104);
      bus.bit_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero(1);
      rst = 1'b0;
      apply(mk(0,0,0,0,0, 1,0,0,0, 0,0,1,0,0), 1110);
      apply(bt(1,0,0,1,0), 1111);
      apply(bt(0,0,0,1,0), 1112);
      apply(bt(1,0,0,1,0), 1113);
      apply(bt(1,1,1,1,0), 1114);
      apply(bt(0,0,1,1,0), 1115);
      apply(bt(1,0,1,1,0), 1116);
      apply(bt(1,1,2,1,0), 1117);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Configurable serial pattern-scan controller for the sequence-detector family. It holds a programmable pattern of 1..MAX_LEN bits, arms and disarms scanning, and sequences detection over a gated serial bitstream. It supports overlap and non-overlap modes and counts hits up to a programmable limit, then stops itself. It sits between the bitstream source and status/interrupt logic and generalises the fixed 1011 Mealy detector into a run-time-configured resource.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..16)
- CNT_W, 8, width of hit counter and hit limit
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived, not overridden)

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  configuration write strobe; honoured only in IDLE
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 = first bit received, bit 0 = last
- cfg_len  in  LEN_W  pattern length; legal 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after each hit
- cfg_max_hits  in  CNT_W  hit limit; 0 = unlimited
- start  in  1  arm scanning (from IDLE or DONE)
- stop  in  1  disarm scanning (from ARMED)
- bit_valid  in  1  bit_in is sampled this cycle
- bit_in  in  1  serial data bit
- match  out  1  one-cycle pulse per detected hit
- match_count  out  CNT_W  hits since last start
- busy  out  1  high in ARMED
- done  out  1  high in DONE (hit limit reached)
- cfg_err  out  1  one-cycle pulse on a rejected cfg_we

## Operation
- States: IDLE, ARMED, DONE. Reset enters IDLE.
- Reset values: pattern = 1011 (low bits, upper bits 0), len = 4, overlap = 1, max_hits = 0. Outputs: match = 0, match_count = 0, busy = 0, done = 0, cfg_err = 0. History and fill count are cleared.
- Config write in IDLE:
  - cfg_len in 1..MAX_LEN: all four fields load.
  - cfg_len = 0 or > MAX_LEN: nothing loads and cfg_err pulses.
  - cfg_we in ARMED or DONE is silently ignored, with no cfg_err.
- IDLE/DONE + start -> ARMED. Clears match_count, history shift register and fill count (0..MAX_LEN, saturating).
- ARMED + stop -> IDLE. match_count is retained. Start and stop in the same cycle: stop wins. Start while ARMED: ignored.
- In ARMED, each cycle with bit_valid = 1:
  - Shift bit_in into the history LSB.
  - Increment the fill count.
- Hit condition:
  - The fill count after the shift is >= len.
  - The low len history bits equal the low len pattern bits.
  - Cycles with bit_valid = 0 change nothing.
- On a hit:
  - match pulses.
  - match_count increments, saturating at all-ones.
  - If overlap = 0, the fill count resets to 0, so the next hit needs len fresh bits.
- Hit limit: if max_hits != 0 and the increment makes match_count == max_hits, the next state is DONE. Bits arriving in DONE are ignored.
- A hit on the same cycle as stop is still counted and pulsed (the bit is processed, then the state goes to IDLE).
- Pattern bits at or above len are don't-care.

## Timing
- match, match_count, busy, done and cfg_err are all registered.
- match and the match_count update appear in the cycle after the rising edge that samples the final pattern bit (1-cycle latency).
- busy rises 1 cycle after start and falls 1 cycle after stop.
- done rises in the same cycle as the final match pulse, because both are registered off the same edge.
- cfg_err is asserted 1 cycle after the rejected cfg_we.
- Back-to-back hits (overlap = 1, len = 1) produce a match pulse on consecutive cycles.
- Reset mid-scan: on the next edge all outputs take reset values. Config also reverts to the 1011 default.

## Test plan
- Default 1011 pattern, overlap: start, stream 1,0,1,1,0,1,1 (valid every cycle) -> match after bits 4 and 7; match_count = 2; busy = 1.
- Non-overlap: write overlap = 0 in IDLE, then stream 1,0,1,1,0,1,1,1,0,1,1 -> hits only after bits 4 and 11; match_count = 2.
- Limit: max_hits = 2, stream 1011011011 -> match pulses after bits 4 and 7; done = 1 and busy = 0 from the second pulse onward; bit 10 gives no pulse; count stays 2. A further start clears the count and re-arms.
- Config guards:
  - cfg_len = 0 in IDLE -> cfg_err pulse, pattern unchanged (1011 still matches).
  - cfg_we with pattern 111, len 3 while ARMED -> ignored, no cfg_err.
- Gapped valid: pattern 0110, len 4; bits 0,1,1,0 with bit_valid low for 3 cycles between each -> exactly one match, 1 cycle after the last valid bit.
- Reset mid-scan: after 1,0,1 assert rst for 1 cycle, then start and stream 1 -> no match. All outputs are 0 after reset, and config is back to default.
